// File: rtl/id_pair_packer_if.sv
// Bus bundle for id_pair_packer.
// Carries the ID-pair input stream (S_AXIS_ID_PAIR_*), the packed output stream (M_AXIS_*)
// and the status outputs (o_PairCount, o_FrameDone).
//   master : the packer's view (consumes pairs, drives the output stream and status)
//   slave  : the environment's view (drives pairs, consumes the output stream)
interface id_pair_packer_if #(
  parameter int unsigned VEC_ID_WIDTH = 8,
  parameter int unsigned OUT_WIDTH    = 128,
  parameter int unsigned CNT_WIDTH    = 32
);
  logic [2*VEC_ID_WIDTH-1:0] S_AXIS_ID_PAIR_tdata;
  logic                      S_AXIS_ID_PAIR_tvalid;
  logic                      S_AXIS_ID_PAIR_tlast;
  logic                      S_AXIS_ID_PAIR_tready;
  logic [OUT_WIDTH-1:0]      M_AXIS_tdata;
  logic [OUT_WIDTH/8-1:0]    M_AXIS_tkeep;
  logic                      M_AXIS_tvalid;
  logic                      M_AXIS_tlast;
  logic                      M_AXIS_tready;
  logic [CNT_WIDTH-1:0]      o_PairCount;
  logic                      o_FrameDone;

  modport master (
    input  S_AXIS_ID_PAIR_tdata, S_AXIS_ID_PAIR_tvalid, S_AXIS_ID_PAIR_tlast, M_AXIS_tready,
    output S_AXIS_ID_PAIR_tready, M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tvalid, M_AXIS_tlast,
    output o_PairCount, o_FrameDone
  );

  modport slave (
    output S_AXIS_ID_PAIR_tdata, S_AXIS_ID_PAIR_tvalid, S_AXIS_ID_PAIR_tlast, M_AXIS_tready,
    input  S_AXIS_ID_PAIR_tready, M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tvalid, M_AXIS_tlast,
    input  o_PairCount, o_FrameDone
  );
endinterface

// File: rtl/id_pair_packer.sv
// Packs a stream of ID pairs into wide output words, lane 0 holding the first pair.
// A word is emitted when its last lane is filled or a pair carries tlast; unused lanes
// are zero and tkeep marks only the bytes of written lanes.
// Ports:
//   ap_clk  : clock, rising edge
//   ap_rstn : synchronous active-low reset
//   bus     : input pair stream, output word stream, pair counter and frame-done pulse
module id_pair_packer #(
  parameter int unsigned VEC_ID_WIDTH   = 8,
  parameter int unsigned OUT_WIDTH      = 128,
  parameter int unsigned PAIRS_PER_WORD = OUT_WIDTH / (2 * VEC_ID_WIDTH),
  parameter int unsigned CNT_WIDTH      = 32
) (
  input logic              ap_clk,
  input logic              ap_rstn,
  id_pair_packer_if.master bus
);

  localparam int unsigned PairW     = 2 * VEC_ID_WIDTH;
  localparam int unsigned PairBytes = PairW / 8;
  localparam int unsigned KeepW     = OUT_WIDTH / 8;
  localparam int unsigned FillW     = (PAIRS_PER_WORD > 1) ? $clog2(PAIRS_PER_WORD) : 1;

  logic [FillW-1:0]     fill_q, fill_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d, acc_word;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic [KeepW-1:0]     keep_q, keep_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 frame_done_q, frame_done_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 s_ready, accept, out_hs, word_done;

  // Input is taken whenever the output register is empty or draining this edge.
  assign s_ready   = !valid_q || bus.M_AXIS_tready;
  assign accept    = bus.S_AXIS_ID_PAIR_tvalid && s_ready;
  assign out_hs    = valid_q && bus.M_AXIS_tready;
  assign word_done = accept &&
                     (bus.S_AXIS_ID_PAIR_tlast || (fill_q == FillW'(PAIRS_PER_WORD - 1)));

  // Accumulator with the incoming pair dropped into the current lane.
  always_comb begin
    acc_word = acc_q;
    for (int l = 0; l < PAIRS_PER_WORD; l++) begin
      if (fill_q == FillW'(l)) begin
        acc_word[l*PairW +: PairW] = bus.S_AXIS_ID_PAIR_tdata;
      end
    end
  end

  always_comb begin
    fill_d       = fill_q;
    acc_d        = acc_q;
    data_d       = data_q;
    keep_d       = keep_q;
    last_d       = last_q;
    valid_d      = valid_q;
    count_d      = count_q;
    frame_done_d = out_hs && last_q;

    if (out_hs) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      if (count_q != '1) begin
        count_d = count_q + CNT_WIDTH'(1);
      end
      if (word_done) begin
        // Completed word replaces (or refills) the output register on this same edge.
        data_d  = acc_word;
        last_d  = bus.S_AXIS_ID_PAIR_tlast;
        valid_d = 1'b1;
        acc_d   = '0;
        fill_d  = '0;
        for (int b = 0; b < KeepW; b++) begin
          keep_d[b] = (b < (int'(fill_q) + 1) * int'(PairBytes));
        end
      end else begin
        acc_d  = acc_word;
        fill_d = fill_q + FillW'(1);
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rstn) begin
      fill_q       <= '0;
      acc_q        <= '0;
      data_q       <= '0;
      keep_q       <= '0;
      last_q       <= 1'b0;
      valid_q      <= 1'b0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      fill_q       <= fill_d;
      acc_q        <= acc_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      last_q       <= last_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.S_AXIS_ID_PAIR_tready = s_ready;
  assign bus.M_AXIS_tdata          = data_q;
  assign bus.M_AXIS_tkeep          = keep_q;
  assign bus.M_AXIS_tvalid         = valid_q;
  assign bus.M_AXIS_tlast          = last_q;
  assign bus.o_PairCount           = count_q;
  assign bus.o_FrameDone           = frame_done_q;

endmodule

// File: doc/id_pair_packer.md
ID_PAIR_PACKER -- requirements
Module: id_pair_packer

Interface
REQ-001 The block SHALL have parameter VEC_ID_WIDTH, default 8, width of one vector ID (2*VEC_ID_WIDTH SHALL be a multiple of 8).
REQ-002 The block SHALL have parameter OUT_WIDTH, default 128, output stream word width (multiple of 2*VEC_ID_WIDTH).
REQ-003 The block SHALL have parameter PAIRS_PER_WORD, default OUT_WIDTH/(2*VEC_ID_WIDTH) (=8), ID pairs per output word.
REQ-004 The block SHALL have parameter CNT_WIDTH, default 32, width of the accepted-pair counter.
REQ-005 The block SHALL have port ap_clk  in  1  single clock; all logic is rising-edge.
REQ-006 The block SHALL have port ap_rstn  in  1  synchronous, active-low reset.
REQ-007 The block SHALL have port S_AXIS_ID_PAIR_tdata  in  2*VEC_ID_WIDTH  ID pair from the comparator pipeline.
REQ-008 The block SHALL have port S_AXIS_ID_PAIR_tvalid  in  1; S_AXIS_ID_PAIR_tlast  in  1  final pair of frame; S_AXIS_ID_PAIR_tready  out  1.
REQ-009 The block SHALL have port M_AXIS_tdata  out  OUT_WIDTH  packed pairs to DMA.
REQ-010 The block SHALL have port M_AXIS_tkeep  out  OUT_WIDTH/8  byte enables; M_AXIS_tvalid  out  1; M_AXIS_tlast  out  1; M_AXIS_tready  in  1.
REQ-011 The block SHALL have port o_PairCount  out  CNT_WIDTH  pairs accepted since reset, saturating.
REQ-012 The block SHALL have port o_FrameDone  out  1  one-cycle pulse on output handshake of a tlast word.

Function
REQ-013 Input handshake SHALL occur when S_AXIS_ID_PAIR_tvalid && S_AXIS_ID_PAIR_tready on a rising edge.
REQ-014 S_AXIS_ID_PAIR_tready SHALL equal (!M_AXIS_tvalid || M_AXIS_tready), combinationally, independent of tvalid/tlast.
REQ-015 Accumulator SHALL hold a fill count n (0..PAIRS_PER_WORD-1); accepted pair SHALL be written to lane n, bits [n*2*VEC_ID_WIDTH +: 2*VEC_ID_WIDTH], lane 0 = first pair.
REQ-016 A word SHALL complete when the accepted pair fills lane PAIRS_PER_WORD-1 or carries tlast.
REQ-017 On completion the word SHALL load into the output register in the same edge; M_AXIS_tvalid SHALL be 1 in the next cycle (latency 1 cycle from completing accept).
REQ-018 On completion n SHALL return to 0 and accumulator lanes SHALL clear to zero.
REQ-019 Lanes not written in a partial word SHALL be zero in M_AXIS_tdata.
REQ-020 M_AXIS_tkeep SHALL have the low k*(2*VEC_ID_WIDTH/8) bits set, k = pairs in word, all others 0.
REQ-021 M_AXIS_tlast SHALL be 1 only for a word completed by a tlast pair.
REQ-022 While M_AXIS_tvalid && !M_AXIS_tready, tdata/tkeep/tlast SHALL stay stable and no input SHALL be accepted.
REQ-023 Output drain and new load in the same edge SHALL be supported (no bubble); continuous input with M_AXIS_tready=1 SHALL sustain one pair per cycle.
REQ-024 o_PairCount SHALL increment by 1 per input handshake and hold at 2^CNT_WIDTH-1.
REQ-025 o_FrameDone SHALL pulse 1 cycle, registered, the cycle after an output handshake with M_AXIS_tlast=1.
REQ-026 Output tvalid SHALL never depend combinationally on M_AXIS_tready.

Reset
REQ-027 While ap_rstn=0 at an edge: M_AXIS_tvalid=0, M_AXIS_tdata=0, M_AXIS_tkeep=0, M_AXIS_tlast=0, o_PairCount=0, o_FrameDone=0, n=0, accumulator=0.
REQ-028 Reset mid-word or with a pending output word SHALL discard all buffered pairs; no partial word SHALL be emitted afterwards.
REQ-029 S_AXIS_ID_PAIR_tready SHALL be 1 in the first cycle after reset release.

Verification
REQ-030 8 pairs 0x0101..0x0808 back-to-back, M_AXIS_tready=1 -> one word, cycle after 8th accept, tdata[15:0]=0x0101, tdata[127:112]=0x0808, tkeep=0xFFFF, tlast=0.
REQ-031 3 pairs 0x0A0B,0x0C0D,0x0E0F, tlast on 3rd -> tdata=0x...0E0F0C0D0A0B with bits[127:48]=0, tkeep=0x003F, tlast=1, o_FrameDone pulse cycle after handshake.
REQ-032 16 pairs offered, M_AXIS_tready=0 for 20 cycles -> exactly 8 accepted, S tready=0 from cycle after 8th accept, output word stable 20 cycles; on release second word follows.
REQ-033 5 pairs accepted then ap_rstn=0 one cycle, then 8 pairs 0x1111.. -> single word containing only new pairs, o_PairCount=8.
REQ-034 17 pairs, tlast on 17th, random M_AXIS_tready -> 3 words, third tkeep=0x0003 tlast=1, o_PairCount=17, no pair lost or duplicated.
REQ-035 64 pairs continuous, M_AXIS_tready=1 -> S tready never deasserts, 8 words, o_PairCount=64.
